// File: rtl/chopper_sequencer.sv
// -----------------------------------------------------------------------------
// chopper_sequencer
//
// Per-coil current chopper. Walks the four H-bridge switches of one coil
// through drive (BLANK/ON), fast decay and slow decay. An all-off DEAD
// interval is inserted on every change of switch set. A sticky overcurrent
// fault is raised after FAULT_COUNT consecutive chop periods in which the
// comparator tripped on the very first cycle it was allowed to.
//
// Ports
//   clk                         system clock
//   reset                       asynchronous, active-high reset
//   enable                      coil enable
//   polarity                    0: drive h1+l2, 1: drive h2+l1
//   analog_cmp                  asynchronous comparator, 1 = current >= target
//   config_offtime[9:0]         decay period length in cycles
//   config_blanktime[7:0]       comparator blanking after drive start
//   config_fastdecay_threshold  decay-counter value where fast decay ends
//   config_minimum_on_time      minimum drive cycles before comparator counts
//   config_invert_highside      invert h gates at the pins
//   config_invert_lowside       invert l gates at the pins
//   phase_1_h/_l, phase_2_h/_l  bridge gate drives (registered)
//   chop_state[2:0]             IDLE=0 DEAD=1 BLANK=2 ON=3 FAST=4 SLOW=5
//   fault                       sticky overcurrent fault
// -----------------------------------------------------------------------------
module chopper_sequencer #(
    parameter int DEADTIME    = 4,
    parameter int FAULT_COUNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       polarity,
    input  logic       analog_cmp,
    input  logic [9:0] config_offtime,
    input  logic [7:0] config_blanktime,
    input  logic [9:0] config_fastdecay_threshold,
    input  logic [7:0] config_minimum_on_time,
    input  logic       config_invert_highside,
    input  logic       config_invert_lowside,
    output logic       phase_1_h,
    output logic       phase_1_l,
    output logic       phase_2_h,
    output logic       phase_2_l,
    output logic [2:0] chop_state,
    output logic       fault
);

    localparam int              FC_W        = $clog2(FAULT_COUNT + 1);
    localparam logic [7:0]      DEAD_LAST   = 8'(DEADTIME - 1);
    localparam logic [FC_W:0]   FAULT_LIMIT = (FC_W + 1)'(FAULT_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_BLANK = 3'd2,
        ST_ON    = 3'd3,
        ST_FAST  = 3'd4,
        ST_SLOW  = 3'd5
    } state_t;

    // Gate vector bit order: [0]=h1 [1]=l1 [2]=h2 [3]=l2
    function automatic logic [3:0] gate_set(input state_t s, input logic pol);
        logic [3:0] g;
        g = 4'b0000;
        case (s)
            ST_BLANK, ST_ON: g = pol ? 4'b0110 : 4'b1001;
            ST_FAST:         g = pol ? 4'b1001 : 4'b0110;
            ST_SLOW:         g = 4'b1010;
            default:         g = 4'b0000;
        endcase
        return g;
    endfunction

    state_t            state_reg, state_next;
    state_t            dead_target_reg, dead_target_next;
    logic [7:0]        dead_cnt_reg, dead_cnt_next;
    logic [7:0]        on_cnt_reg, on_cnt_next;
    logic [9:0]        dcnt_reg, dcnt_next;
    logic [FC_W-1:0]   fault_cnt_reg, fault_cnt_next;
    logic              fault_reg, fault_next;
    logic              drv_pol_reg, drv_pol_next;
    logic [1:0]        cmp_sync_reg;
    logic              cmp_s;
    logic [3:0]        gate_reg, gate_next;
    logic [3:0]        invert_mask, pin;

    logic [7:0]        blank_floor, qual_point, on_cnt_inc;
    logic [9:0]        dcnt_dec;
    logic              blank_done, fast_done, slow_done, fault_trip;
    state_t            decay_target;

    // Two-flop synchroniser for the asynchronous comparator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_sync_reg <= 2'b00;
        end else begin
            cmp_sync_reg <= {cmp_sync_reg[0], analog_cmp};
        end
    end
    assign cmp_s = cmp_sync_reg[1];

    // The first ON cycle always has on_cnt >= 1 (BLANK lasts at least one
    // cycle), so the first qualified cycle is floored at 1.
    assign blank_floor  = (config_blanktime == 8'd0) ? 8'd1 : config_blanktime;
    assign qual_point   = (config_minimum_on_time > blank_floor) ? config_minimum_on_time : blank_floor;
    assign on_cnt_inc   = (on_cnt_reg == 8'hFF) ? 8'hFF : on_cnt_reg + 8'd1;
    assign dcnt_dec     = (dcnt_reg == 10'd0) ? 10'd0 : dcnt_reg - 10'd1;
    assign blank_done   = ({1'b0, on_cnt_reg} + 9'd1) >= {1'b0, config_blanktime};
    // Fast decay ends on the cycle whose decrement lands on the threshold
    assign fast_done    = {1'b0, dcnt_reg} <= ({1'b0, config_fastdecay_threshold} + 11'd1);
    assign slow_done    = dcnt_reg <= 10'd1;
    assign fault_trip   = ({1'b0, fault_cnt_reg} + (FC_W + 1)'(1)) >= FAULT_LIMIT;
    assign decay_target = (config_fastdecay_threshold >= config_offtime) ? ST_SLOW : ST_FAST;

    always_comb begin
        state_next       = state_reg;
        dead_target_next = dead_target_reg;
        dead_cnt_next    = dead_cnt_reg;
        on_cnt_next      = on_cnt_reg;
        dcnt_next        = dcnt_reg;
        fault_cnt_next   = fault_cnt_reg;
        fault_next       = fault_reg;
        drv_pol_next     = drv_pol_reg;

        if (!enable) begin
            // Disable overrides everything and clears the fault history
            fault_next     = 1'b0;
            fault_cnt_next = '0;
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_DEAD: begin
                    dead_target_next = ST_IDLE;
                    if (dead_cnt_reg == DEAD_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        dead_cnt_next = dead_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next       = ST_DEAD;
                    dead_cnt_next    = 8'd0;
                    dead_target_next = ST_IDLE;
                end
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fault_reg) begin
                        state_next   = ST_BLANK;
                        on_cnt_next  = 8'd0;
                        drv_pol_next = polarity;
                    end
                end
                ST_DEAD: begin
                    // dcnt is deliberately left untouched here
                    if (dead_cnt_reg == DEAD_LAST) begin
                        state_next = dead_target_reg;
                        if (dead_target_reg == ST_BLANK) begin
                            on_cnt_next  = 8'd0;
                            drv_pol_next = polarity;
                        end
                    end else begin
                        dead_cnt_next = dead_cnt_reg + 8'd1;
                    end
                end
                ST_BLANK: begin
                    on_cnt_next = on_cnt_inc;
                    if (blank_done) begin
                        state_next = ST_ON;
                    end
                end
                ST_ON: begin
                    on_cnt_next = on_cnt_inc;
                    if (polarity != drv_pol_reg) begin
                        state_next       = ST_DEAD;
                        dead_cnt_next    = 8'd0;
                        dead_target_next = ST_BLANK;
                        fault_cnt_next   = '0;
                    end else if (cmp_s && (on_cnt_reg >= config_minimum_on_time)) begin
                        state_next       = ST_DEAD;
                        dead_cnt_next    = 8'd0;
                        dead_target_next = decay_target;
                        dcnt_next        = config_offtime;
                        if (on_cnt_reg == qual_point) begin
                            if (fault_trip) begin
                                fault_next       = 1'b1;
                                fault_cnt_next   = FAULT_LIMIT[FC_W-1:0];
                                dead_target_next = ST_IDLE;
                            end else begin
                                fault_cnt_next = fault_cnt_reg + FC_W'(1);
                            end
                        end else begin
                            fault_cnt_next = '0;
                        end
                    end
                end
                ST_FAST: begin
                    dcnt_next = dcnt_dec;
                    if (fast_done) begin
                        state_next       = ST_DEAD;
                        dead_cnt_next    = 8'd0;
                        dead_target_next = ST_SLOW;
                    end
                end
                ST_SLOW: begin
                    dcnt_next = dcnt_dec;
                    if (slow_done) begin
                        state_next       = ST_DEAD;
                        dead_cnt_next    = 8'd0;
                        dead_target_next = ST_BLANK;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Gates are computed from the next state so they change on the same
    // edge as chop_state.
    assign gate_next = gate_set(state_next, drv_pol_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            dead_target_reg <= ST_IDLE;
            dead_cnt_reg    <= 8'd0;
            on_cnt_reg      <= 8'd0;
            dcnt_reg        <= 10'd0;
            fault_cnt_reg   <= '0;
            fault_reg       <= 1'b0;
            drv_pol_reg     <= 1'b0;
            gate_reg        <= 4'b0000;
        end else begin
            state_reg       <= state_next;
            dead_target_reg <= dead_target_next;
            dead_cnt_reg    <= dead_cnt_next;
            on_cnt_reg      <= on_cnt_next;
            dcnt_reg        <= dcnt_next;
            fault_cnt_reg   <= fault_cnt_next;
            fault_reg       <= fault_next;
            drv_pol_reg     <= drv_pol_next;
            gate_reg        <= gate_next;
        end
    end

    // Pin polarity is static board configuration, applied after the gate
    // register so that reset drives the inactive level of each pin.
    assign invert_mask = {config_invert_lowside, config_invert_highside,
                          config_invert_lowside, config_invert_highside};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pin
            assign pin[gi] = gate_reg[gi] ^ invert_mask[gi];
        end
    endgenerate

    assign phase_1_h  = pin[0];
    assign phase_1_l  = pin[1];
    assign phase_2_h  = pin[2];
    assign phase_2_l  = pin[3];
    assign chop_state = state_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_chopper_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chopper_sequencer
//
// Directed and randomized chop periods. The expected behaviour is built as a
// list of (state, gate set, duration) segments derived from the chopping
// rules; the observed per-cycle state/gates are run-length compressed and
// compared segment by segment.
// -----------------------------------------------------------------------------
module tb_chopper_sequencer;

    localparam int D = 4;
    localparam int S_IDLE = 0, S_DEAD = 1, S_BLANK = 2, S_ON = 3, S_FAST = 4, S_SLOW = 5;
    localparam int G_OFF = 0, G_SLOW = 10;

    logic       clk = 1'b0;
    logic       reset, enable, polarity, analog_cmp;
    logic [9:0] config_offtime, config_fastdecay_threshold;
    logic [7:0] config_blanktime, config_minimum_on_time;
    logic       config_invert_highside, config_invert_lowside;
    logic       phase_1_h, phase_1_l, phase_2_h, phase_2_l;
    logic [2:0] chop_state;
    logic       fault;

    always #5 clk = ~clk;

    chopper_sequencer #(.DEADTIME(D), .FAULT_COUNT(8)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .enable                     (enable),
        .polarity                   (polarity),
        .analog_cmp                 (analog_cmp),
        .config_offtime             (config_offtime),
        .config_blanktime           (config_blanktime),
        .config_fastdecay_threshold (config_fastdecay_threshold),
        .config_minimum_on_time     (config_minimum_on_time),
        .config_invert_highside     (config_invert_highside),
        .config_invert_lowside      (config_invert_lowside),
        .phase_1_h                  (phase_1_h),
        .phase_1_l                  (phase_1_l),
        .phase_2_h                  (phase_2_h),
        .phase_2_l                  (phase_2_l),
        .chop_state                 (chop_state),
        .fault                      (fault)
    );

    typedef struct {
        int st;
        int g;
        int len;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] gates;
    assign gates = {phase_2_l, phase_2_h, phase_1_l, phase_1_h};

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, expv);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int drive_g(input int p);
        return (p != 0) ? 6 : 9;
    endfunction

    function automatic int fast_g(input int p);
        return (p != 0) ? 9 : 6;
    endfunction

    task automatic add_seg(input int st, input int g, input int len);
        seg_t s;
        s.st = st; s.g = g; s.len = len;
        if (len > 0) exp_q.push_back(s);
    endtask

    // One chop period from the first BLANK cycle (index 0). The comparator
    // is raised during cycle c, so the synchronised copy is seen from c+2.
    // ON ends on the first cycle where drive time >= blanking, >= minimum
    // on-time and the synchronised comparator is high.
    task automatic model_period(input int bl, input int mo, input int off, input int thr,
                                input int c, input int p, input bit trip,
                                output int len, output int e,
                                output int slow_start, output int slow_len);
        int bf;
        bf = imax(bl, 1);
        e  = imax(imax(bf, mo), c + 2);
        add_seg(S_BLANK, drive_g(p), bf);
        add_seg(S_ON, drive_g(p), e - bf + 1);
        add_seg(S_DEAD, G_OFF, D);
        len = e + 1 + D;
        slow_start = -1;
        slow_len   = 0;
        if (!trip) begin
            if (thr >= off) begin
                slow_len = imax(off, 1);
            end else begin
                add_seg(S_FAST, fast_g(p), off - thr);
                add_seg(S_DEAD, G_OFF, D);
                len += off - thr + D;
                slow_len = imax(thr, 1);
            end
            slow_start = len;
            add_seg(S_SLOW, G_SLOW, slow_len);
            add_seg(S_DEAD, G_OFF, D);
            len += slow_len + D;
        end
    endtask

    // Runs ncyc cycles starting at the first BLANK cycle, driving the
    // comparator high over [cmp_on, cmp_off) and flipping polarity at tog.
    task automatic run(input int ncyc, input int cmp_on, input int cmp_off, input int tog,
                       input string tag, output int first_fault);
        seg_t cur;
        int   st, g, n;
        bit   no_shoot;
        obs_q.delete();
        first_fault = -1;
        no_shoot = 1'b1;
        cur.st = -1; cur.g = -1; cur.len = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            st = int'(chop_state);
            g  = int'(gates);
            if (gates[0] && gates[1]) no_shoot = 1'b0;
            if (gates[2] && gates[3]) no_shoot = 1'b0;
            if (fault === 1'b1 && first_fault < 0) first_fault = cyc;
            if (cur.len > 0 && cur.st == st && cur.g == g) begin
                cur.len++;
            end else begin
                if (cur.len > 0) obs_q.push_back(cur);
                cur.st = st; cur.g = g; cur.len = 1;
            end
            analog_cmp = (cyc >= cmp_on && cyc < cmp_off);
            if (cyc == tog) polarity = ~polarity;
        end
        if (cur.len > 0) obs_q.push_back(cur);
        chk(obs_q.size(), exp_q.size(), $sformatf("%s segment_count", tag));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk(obs_q[i].st,  exp_q[i].st,  $sformatf("%s seg%0d state", tag, i));
            chk(obs_q[i].g,   exp_q[i].g,   $sformatf("%s seg%0d gates", tag, i));
            chk(obs_q[i].len, exp_q[i].len, $sformatf("%s seg%0d length", tag, i));
        end
        chk(no_shoot, 1, $sformatf("%s no_shoot_through", tag));
        exp_q.delete();
    endtask

    task automatic go_idle(input string tag);
        int n;
        n = 0;
        enable = 1'b0;
        analog_cmp = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (chop_state != 3'd0 && n < 12);
        chk(chop_state, S_IDLE, $sformatf("%s return_idle", tag));
        chk(fault, 0, $sformatf("%s fault_clear", tag));
    endtask

    initial begin : stim
        int len, e, ss, sl, ff, ff_exp, acc, bl, mo, off, thr, c, p, np, tog, bf;
        reset = 1'b1; enable = 1'b0; polarity = 1'b0; analog_cmp = 1'b0;
        config_offtime = '0; config_fastdecay_threshold = '0;
        config_blanktime = '0; config_minimum_on_time = '0;
        config_invert_highside = 1'b0; config_invert_lowside = 1'b0;

        // Reset values and pin inversion
        repeat (3) @(posedge clk);
        #1;
        chk(chop_state, S_IDLE, "reset state");
        chk(gates, 0, "reset gates");
        chk(fault, 0, "reset fault");
        config_invert_highside = 1'b1; config_invert_lowside = 1'b1;
        #1;
        chk(gates, 15, "reset gates inverted");
        config_invert_lowside = 1'b0;
        #1;
        chk(gates, 5, "reset gates high_inverted");
        config_invert_highside = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk(chop_state, S_IDLE, "idle while disabled");

        // Full drive/fast/slow period, then drive holding with comparator low
        config_blanktime = 8'd27; config_minimum_on_time = 8'd54;
        config_offtime = 10'd810; config_fastdecay_threshold = 10'd706;
        polarity = 1'b0; enable = 1'b1;
        model_period(27, 54, 810, 706, 10, 0, 1'b0, len, e, ss, sl);
        add_seg(S_BLANK, drive_g(0), 27);
        add_seg(S_ON, drive_g(0), 300);
        run(len + 27 + 300, 10, e + 1, -1, "fast_slow", ff);
        chk(ff, -1, "fast_slow no_fault");
        go_idle("fast_slow");

        // Threshold above offtime: slow decay only
        config_fastdecay_threshold = 10'd900;
        enable = 1'b1;
        model_period(27, 54, 810, 900, 10, 0, 1'b0, len, e, ss, sl);
        add_seg(S_BLANK, drive_g(0), 27);
        add_seg(S_ON, drive_g(0), 20);
        run(len + 47, 10, e + 1, -1, "slow_only", ff);
        go_idle("slow_only");

        // Polarity change during ON restarts drive through dead time
        config_blanktime = 8'd5; config_minimum_on_time = 8'd0;
        polarity = 1'b0; enable = 1'b1;
        add_seg(S_BLANK, drive_g(0), 5);
        add_seg(S_ON, drive_g(0), 8);
        add_seg(S_DEAD, G_OFF, D);
        add_seg(S_BLANK, drive_g(1), 5);
        add_seg(S_ON, drive_g(1), 20);
        run(42, 1000, 1000, 12, "pol_in_on", ff);
        go_idle("pol_in_on");

        // Randomized periods; odd iterations flip polarity during slow decay
        for (int i = 0; i < 8; i++) begin
            bl  = $urandom_range(0, 20);
            mo  = $urandom_range(0, 30);
            off = $urandom_range(0, 60);
            thr = $urandom_range(0, 70);
            c   = $urandom_range(0, 40);
            p   = $urandom_range(0, 1);
            config_blanktime = 8'(bl); config_minimum_on_time = 8'(mo);
            config_offtime = 10'(off); config_fastdecay_threshold = 10'(thr);
            polarity = p[0]; enable = 1'b1;
            model_period(bl, mo, off, thr, c, p, 1'b0, len, e, ss, sl);
            if ((i % 2) == 1) begin
                tog = ss + $urandom_range(0, sl - 1);
                np  = 1 - p;
            end else begin
                tog = -1;
                np  = p;
            end
            bf = imax(bl, 1);
            add_seg(S_BLANK, drive_g(np), bf);
            add_seg(S_ON, drive_g(np), 10);
            run(len + bf + 10, c, e + 1, tog,
                $sformatf("rand%0d(b%0d m%0d o%0d t%0d c%0d p%0d)", i, bl, mo, off, thr, c, p), ff);
            chk(ff, -1, $sformatf("rand%0d no_fault", i));
            go_idle($sformatf("rand%0d", i));
        end

        // Comparator stuck high: eight immediate exits latch the fault
        config_blanktime = 8'd3; config_minimum_on_time = 8'd5;
        config_offtime = 10'd10; config_fastdecay_threshold = 10'd4;
        polarity = 1'b0; analog_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        acc = 0;
        ff_exp = -1;
        for (int k = 1; k <= 8; k++) begin
            model_period(3, 5, 10, 4, -2, 0, (k == 8), len, e, ss, sl);
            if (k == 8) ff_exp = acc + e + 1;
            acc += len;
        end
        add_seg(S_IDLE, G_OFF, 20);
        run(acc + 20, 0, 100000, -1, "fault", ff);
        chk(ff, ff_exp, "fault assert_cycle");
        chk(fault, 1, "fault held");
        enable = 1'b0;
        @(posedge clk); #1;
        chk(fault, 0, "fault cleared_by_disable");
        chk(chop_state, S_IDLE, "fault idle_after_disable");
        analog_cmp = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        chk(chop_state, S_BLANK, "reenable blank");
        chk(gates, drive_g(0), "reenable gates");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chopper_sequencer.md
Name: chopper_sequencer

Overview:
- Per-coil current-chopper controller: sequences the four H-bridge switches of one motor coil through drive, blanking, fast-decay and slow-decay phases, with enforced dead time.
- Sits between the microstep current-target logic (polarity, enable) plus the analog comparator, and the bridge gate pins.
- One instance per coil inside microstepper_top.

Parameters:
- DEADTIME, 4: all-switches-off cycles inserted on every switch-set change; legal range 1..255.
- FAULT_COUNT, 8: consecutive chop periods with comparator high at first qualified ON cycle before fault latches.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  coil enable
- polarity  in  1  0: drive h1+l2; 1: drive h2+l1
- analog_cmp  in  1  async comparator; 1 = current >= target
- config_offtime  in  10  decay period length, cycles
- config_blanktime  in  8  comparator blanking after drive start
- config_fastdecay_threshold  in  10  decay-counter value where fast decay ends
- config_minimum_on_time  in  8  minimum drive cycles before comparator is honoured
- config_invert_highside  in  1  invert h outputs at pins
- config_invert_lowside  in  1  invert l outputs at pins
- phase_1_h, phase_1_l, phase_2_h, phase_2_l  out  1 each  bridge gates, registered
- chop_state  out  3  current state encoding
- fault  out  1  sticky overcurrent fault

Behaviour:
- State encoding: IDLE=0, DEAD=1, BLANK=2, ON=3, FAST=4, SLOW=5. All outputs are registered and change on the same edge as chop_state.
- Pre-inversion switch sets:
  - IDLE/DEAD: all off
  - BLANK/ON: pol0 h1,l2; pol1 h2,l1
  - FAST: opposite of drive
  - SLOW: l1,l2
  - Inversion XORs each output with its config bit.
- Reset: state IDLE, all counters 0, fault 0; outputs = invert bits (all 0 when invert=0).
- Invariant: never h1&l1 or h2&l2 pre-inversion.
- Comparator: 2-flop synchroniser; cmp_s is its output. All references below use cmp_s.
- DEAD:
  - Counts DEADTIME cycles, then enters the stored next_state.
  - Every transition between non-IDLE states with different switch sets passes through DEAD.
  - IDLE->BLANK is direct.
- BLANK:
  - Latches polarity into drv_pol on entry; on_cnt cleared to 0 on entry.
  - on_cnt increments each BLANK/ON cycle, saturating at 255.
  - After config_blanktime cycles -> ON. blanktime=0 -> one BLANK cycle.
- ON:
  - If cmp_s && on_cnt >= config_minimum_on_time -> DEAD, then FAST. The decay counter dcnt loads config_offtime.
  - If polarity != drv_pol -> DEAD, then BLANK (new polarity). The polarity check has priority over cmp_s in the same cycle.
  - Otherwise stays ON indefinitely.
- FAST: dcnt decrements each cycle; when dcnt reaches config_fastdecay_threshold -> DEAD, then SLOW.
- Entry to decay when threshold >= offtime: go straight to SLOW (no FAST).
- SLOW: dcnt decrements each cycle; on reaching 0 -> DEAD, then BLANK. Polarity changes during decay take effect only at that BLANK.
- dcnt freezes during DEAD.
- offtime=0: SLOW lasts one cycle.
- Fault counting:
  - A period is counted when ON is left on its first qualified cycle (on_cnt == max(blanktime, minimum_on_time)) via cmp_s.
  - fault_cnt increments per counted period and clears on any other ON exit.
  - When fault_cnt reaches FAULT_COUNT: fault=1 and the block goes DEAD -> IDLE, holding IDLE while fault=1.
  - fault clears only when enable=0 or reset.
- Enable:
  - enable=0 in any state -> DEAD (unless IDLE) -> IDLE. This overrides all other transitions. fault_cnt and fault clear.
  - enable=1 in IDLE with fault=0 -> BLANK next edge.
- Config inputs are sampled live. Changes mid-period affect subsequent comparisons only.

Test Plan:
- Reset with invert=0 -> all gates 0, chop_state=0, fault=0. Invert high=1, low=1 -> phase_*_h=1, phase_*_l=1.
- DEADTIME=4, blank=27, min_on=54, enable=1, pol=0, cmp=0 -> BLANK 27 cycles with h1,l2, then ON holds h1,l2 forever.
- Same config, offtime=810, threshold=706, cmp rises at drive cycle 10 -> ON exits at on_cnt=54 (+2 sync). Then DEAD 4, FAST (h2,l1) 104 cycles, DEAD 4, SLOW (l1,l2) 706 cycles, DEAD 4, BLANK.
- Polarity toggles 0->1 during ON -> DEAD 4 cycles all off, then BLANK driving h2,l1. Toggle during SLOW -> no effect until next BLANK.
- threshold=900 > offtime=810 -> decay is SLOW only, 810 cycles.
- cmp held 1 -> eight consecutive immediate exits -> fault=1, state IDLE, all off. Drop enable one cycle -> fault=0; re-enable -> BLANK.
